// File: rtl/mux_rr_fifo.sv
// N-channel word multiplexer. Each channel owns a DEPTH-word FIFO; a scheduler
// drains them onto one registered output. There are two scheduling modes:
// work-conserving round-robin (MODE=0) and fixed TDM slots (MODE=1).
module mux_rr_fifo #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int MODE  = 0
) (
  input  logic                 clk_4f,
  input  logic                 reset,
  input  logic [N*W-1:0]       entrada,
  input  logic [N-1:0]         valid_entrada,
  input  logic                 pausa,
  output logic [W-1:0]         salida,
  output logic                 valid_salida,
  output logic [$clog2(N)-1:0] canal_salida,
  output logic [N-1:0]         llenos,
  output logic [N-1:0]         overflow
);

  localparam int PW = $clog2(N);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  r_mem    [N][DEPTH];
  logic [AW-1:0] r_wr_ptr [N];
  logic [AW-1:0] r_rd_ptr [N];
  logic [CW-1:0] r_cnt    [N];
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_slot;
  logic [W-1:0]  r_salida;
  logic          r_valid;
  logic [PW-1:0] r_canal;
  logic [N-1:0]  r_llenos;
  logic [N-1:0]  r_overflow;

  logic [PW-1:0] w_sel;
  logic          w_any;
  logic [N-1:0]  w_pop;
  logic [N-1:0]  w_push;
  logic [W-1:0]  w_head;
  logic [CW-1:0] w_cnt_next [N];

  // Channel index increment. N need not be a power of two, so the wrap is explicit.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return (v == PW'(N - 1)) ? '0 : v + PW'(1);
  endfunction

  // Choose the channel to pop. The choice looks only at registered counts, so a
  // word written on this edge cannot be popped before the following edge.
  always_comb begin
    int idx;
    idx   = 0;
    w_sel = '0;
    w_any = 1'b0;
    if (MODE == 1) begin
      w_sel = r_slot;
      w_any = (r_cnt[r_slot] != '0);
    end else begin
      // Walk from farthest to nearest so the nearest non-empty channel wins.
      for (int k = N - 1; k >= 0; k--) begin
        idx = (int'(r_ptr) + k) % N;
        if (r_cnt[idx] != '0) begin
          w_sel = PW'(idx);
          w_any = 1'b1;
        end
      end
    end
  end

  // Pop/push strobes and next counts. A full FIFO still takes a word when it is
  // popped on the same edge.
  always_comb begin
    w_pop  = '0;
    w_push = '0;
    w_head = r_mem[w_sel][r_rd_ptr[w_sel]];
    if (!pausa && w_any) w_pop[w_sel] = 1'b1;
    for (int i = 0; i < N; i++) begin
      w_push[i]     = valid_entrada[i] && ((r_cnt[i] != FULL) || w_pop[i]);
      w_cnt_next[i] = r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
    end
  end

  // FIFO storage. The contents need no reset because the counts gate every read.
  always_ff @(posedge clk_4f) begin
    for (int i = 0; i < N; i++)
      if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= entrada[i*W +: W];
  end

  // Per-channel pointers, counts, full flags and sticky drop flags.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_cnt[i]    <= '0;
      end
      r_llenos   <= '0;
      r_overflow <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + AW'(1);
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + AW'(1);
        r_cnt[i]      <= w_cnt_next[i];
        r_llenos[i]   <= (w_cnt_next[i] == FULL);
        if (valid_entrada[i] && !w_push[i]) r_overflow[i] <= 1'b1;
      end
    end
  end

  // Scheduler and output register. While paused, everything is frozen.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      r_ptr    <= '0;
      r_slot   <= '0;
      r_salida <= '0;
      r_valid  <= 1'b0;
      r_canal  <= '0;
    end else if (!pausa) begin
      if (MODE == 1) begin
        r_slot  <= wrap_inc(r_slot);
        r_canal <= r_slot;
        r_valid <= w_any;
        if (w_any) r_salida <= w_head;
      end else begin
        r_valid <= w_any;
        if (w_any) begin
          r_salida <= w_head;
          r_canal  <= w_sel;
          r_ptr    <= wrap_inc(w_sel);
        end
      end
    end
  end

  assign salida       = r_salida;
  assign valid_salida = r_valid;
  assign canal_salida = r_canal;
  assign llenos       = r_llenos;
  assign overflow     = r_overflow;

endmodule
